id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register for the RV64I+Zba core. Sits directly downstream of the
//  decode-stage control unit and register file. Captures decoded control and operands,
//  and detects load-use hazards against the instruction held in EX. Turns flushes
//  (taken branch/jump) and load-use stalls into bubbles, and keeps saturating
//  counters of both events.
// PARAMETERS
//  XLEN   64  datapath width (RD1/RD2/PC/Imm/PCPlus4)
//  CNT_W  16  width of each event counter
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst_n        in   1      asynchronous reset, active-low
//  RegWriteD    in   1      decode control
//  ResultSrcD   in   2      decode control (2'b01 = load)
//  MemWriteD    in   1      decode control
//  JumpD        in   1      decode control
//  BranchD      in   1      decode control
//  ALUSrcD      in   1      decode control
//  ALUControlD  in   5      decode ALU operation
//  ValidD       in   1      decode slot holds a real instruction
//  RD1D, RD2D   in   XLEN   register-file read data
//  PCD          in   XLEN   decode PC
//  ImmExtD      in   XLEN   extended immediate
//  PCPlus4D     in   XLEN   PC+4
//  Rs1D,Rs2D,RdD in  5      register indices
//  PCSrcE       in   1      redirect resolved in EX this cycle (taken branch/jump)
//  <name>E      out  same   registered copy of every <name>D above (ValidD -> ValidE)
//  StallF       out  1      hold fetch PC
//  StallD       out  1      hold IF/ID register
//  FlushD       out  1      squash IF/ID register
//  lu_cnt       out  CNT_W  load-use bubbles inserted
//  fl_cnt       out  CNT_W  flush bubbles inserted
// BEHAVIOUR
//  Reset: on rst_n low, all registered outputs and both counters go to 0 immediately.
//   Reset is not gated by clk. A mid-operation reset discards the EX instruction.
//  Hazard detect, combinational from EX state plus D indices:
//   lw_hz = ValidE & (ResultSrcE==2'b01) & (RdE!=0) & ((Rs1D==RdE)|(Rs2D==RdE))
//   Rs1D/Rs2D are compared even for formats that do not read them (conservative).
//  Stall and flush outputs:
//   FlushD = PCSrcE.
//   StallF = StallD = lw_hz & ~PCSrcE. A redirect always overrides a stall.
//  Next state, one edge, priority order:
//   1. PCSrcE: bubble; fl_cnt+1.
//   2. lw_hz: bubble; lu_cnt+1.
//   3. Otherwise: load all D fields into E; ValidE <= ValidD.
//  Bubble: ValidE=0 and every control output=0 (RegWriteE, MemWriteE, JumpE, BranchE,
//   ALUSrcE, ResultSrcE, ALUControlE). Rs1E/Rs2E/RdE=0 so no forwarding matches.
//   Data outputs are 0.
//  ValidD=0 in case 3: register as a bubble, with no counter change.
//  Counters saturate at all-ones and never wrap. Both counters never increment on the
//   same edge.
//  Latency: 1 cycle D->E. No combinational path from any *D data input to any *E output.
//  Loads never assert PCSrcE, so PCSrcE and lw_hz are exclusive in legal code.
//   If both are seen, rule 1 applies.
// TESTING
//  Reset: drive inputs non-zero, pulse rst_n low mid-cycle -> all E outputs, StallF,
//   and counters read 0 without waiting for a clock edge.
//  Pass-through: ADDW in D (ALUControlD=5'b01000, RegWriteD=1, RdD=5, ValidD=1) ->
//   next cycle ALUControlE=5'b01000, RdE=5, ValidE=1, no stall.
//  Load-use: ld x7 in E, then add x8,x7,x1 in D -> StallF=StallD=1 for one cycle.
//   The bubble enters E (ValidE=0, RegWriteE=0) and lu_cnt=1. The add enters E next cycle.
//  RdE=x0 load: ld x0 in E, Rs1D=0 -> no stall, lu_cnt unchanged.
//  Flush: PCSrcE=1 with a valid sub in D -> FlushD=1, E bubble next cycle, fl_cnt=1.
//  Forced conflict plus saturation: force lw_hz and PCSrcE together -> StallF=0,
//   fl_cnt+1, lu_cnt unchanged. Preload fl_cnt to 16'hFFFF, flush again -> stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_if.sv
// ID->EX boundary bundle: decode-side fields in, execute-side registered copies,
// hazard controls and event counters out.
interface id_ex_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
);
   logic             RegWriteD;
   logic [1:0]       ResultSrcD;
   logic             MemWriteD;
   logic             JumpD;
   logic             BranchD;
   logic             ALUSrcD;
   logic [4:0]       ALUControlD;
   logic             ValidD;
   logic [XLEN-1:0]  RD1D;
   logic [XLEN-1:0]  RD2D;
   logic [XLEN-1:0]  PCD;
   logic [XLEN-1:0]  ImmExtD;
   logic [XLEN-1:0]  PCPlus4D;
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic [4:0]       RdD;
   logic             PCSrcE;

   logic             RegWriteE;
   logic [1:0]       ResultSrcE;
   logic             MemWriteE;
   logic             JumpE;
   logic             BranchE;
   logic             ALUSrcE;
   logic [4:0]       ALUControlE;
   logic             ValidE;
   logic [XLEN-1:0]  RD1E;
   logic [XLEN-1:0]  RD2E;
   logic [XLEN-1:0]  PCE;
   logic [XLEN-1:0]  ImmExtE;
   logic [XLEN-1:0]  PCPlus4E;
   logic [4:0]       Rs1E;
   logic [4:0]       Rs2E;
   logic [4:0]       RdE;
   logic             StallF;
   logic             StallD;
   logic             FlushD;
   logic [CNT_W-1:0] lu_cnt;
   logic [CNT_W-1:0] fl_cnt;

   modport master (
      output RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUControlD,
             ValidD, RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD, PCSrcE,
      input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
             ValidE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE,
             StallF, StallD, FlushD, lu_cnt, fl_cnt
   );

   modport slave (
      input  RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUControlD,
             ValidD, RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD, PCSrcE,
      output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
             ValidE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE,
             StallF, StallD, FlushD, lu_cnt, fl_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection, flush/stall bubble
// insertion and saturating counters of both bubble kinds.
module id_ex_stage #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input logic   clk,
   input logic   rst_n,
   id_ex_if.slave bus
);
   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic [1:0]      result_src;
      logic            mem_write;
      logic            jump;
      logic            branch;
      logic            alu_src;
      logic [4:0]      alu_ctrl;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc_plus4;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
   } ex_slot_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ex_slot_t         r_e;
   ex_slot_t         w_e_next;
   ex_slot_t         w_d;
   logic             w_lw_hz;
   logic [CNT_W-1:0] r_lu_cnt;
   logic [CNT_W-1:0] r_fl_cnt;

   // Rs1/Rs2 compared regardless of instruction format: a spurious stall is safe.
   assign w_lw_hz = r_e.valid && (r_e.result_src == 2'b01) && (r_e.rd != 5'd0) &&
                    ((bus.Rs1D == r_e.rd) || (bus.Rs2D == r_e.rd));

   always_comb begin
      w_d.valid      = 1'b1;
      w_d.reg_write  = bus.RegWriteD;
      w_d.result_src = bus.ResultSrcD;
      w_d.mem_write  = bus.MemWriteD;
      w_d.jump       = bus.JumpD;
      w_d.branch     = bus.BranchD;
      w_d.alu_src    = bus.ALUSrcD;
      w_d.alu_ctrl   = bus.ALUControlD;
      w_d.rd1        = bus.RD1D;
      w_d.rd2        = bus.RD2D;
      w_d.pc         = bus.PCD;
      w_d.imm        = bus.ImmExtD;
      w_d.pc_plus4   = bus.PCPlus4D;
      w_d.rs1        = bus.Rs1D;
      w_d.rs2        = bus.Rs2D;
      w_d.rd         = bus.RdD;
   end

   // Flush, load-use and an empty decode slot all yield an all-zero bubble.
   always_comb begin
      w_e_next = '0;
      if (!bus.PCSrcE && !w_lw_hz && bus.ValidD) begin
         w_e_next = w_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_e      <= '0;
         r_lu_cnt <= '0;
         r_fl_cnt <= '0;
      end else begin
         r_e <= w_e_next;
         if (bus.PCSrcE) begin
            if (r_fl_cnt != '1) begin
               r_fl_cnt <= r_fl_cnt + CNT_ONE;
            end
         end else if (w_lw_hz) begin
            if (r_lu_cnt != '1) begin
               r_lu_cnt <= r_lu_cnt + CNT_ONE;
            end
         end
      end
   end

   assign bus.FlushD      = bus.PCSrcE;
   assign bus.StallF      = w_lw_hz && !bus.PCSrcE;
   assign bus.StallD      = w_lw_hz && !bus.PCSrcE;
   assign bus.lu_cnt      = r_lu_cnt;
   assign bus.fl_cnt      = r_fl_cnt;

   assign bus.ValidE      = r_e.valid;
   assign bus.RegWriteE   = r_e.reg_write;
   assign bus.ResultSrcE  = r_e.result_src;
   assign bus.MemWriteE   = r_e.mem_write;
   assign bus.JumpE       = r_e.jump;
   assign bus.BranchE     = r_e.branch;
   assign bus.ALUSrcE     = r_e.alu_src;
   assign bus.ALUControlE = r_e.alu_ctrl;
   assign bus.RD1E        = r_e.rd1;
   assign bus.RD2E        = r_e.rd2;
   assign bus.PCE         = r_e.pc;
   assign bus.ImmExtE     = r_e.imm;
   assign bus.PCPlus4E    = r_e.pc_plus4;
   assign bus.Rs1E        = r_e.rs1;
   assign bus.Rs2E        = r_e.rs2;
   assign bus.RdE         = r_e.rd;
endmodule
